// File: rtl/seq_detect_prog.sv
// ---------------------------------------------------------------------------
// seq_detect_prog
// Programmable serial bit-sequence detector. The pattern, its length
// (1..PAT_W) and the overlap mode are loaded at runtime. The block emits a
// registered one-cycle match pulse and, optionally, a saturating match count.
//
// Build option:
//   MATCH_COUNT_EN  defined   : saturating match counter drives match_count
//                   undefined : no counter logic, match_count tied to 0
//
// Ports:
//   clk          in   1      clock, all logic on posedge
//   clear        in   1      synchronous active-high reset
//   x            in   1      serial data bit
//   x_valid      in   1      x is sampled only when high
//   cfg_load     in   1      strobe: latch cfg_*, flush history
//   cfg_pattern  in   PAT_W  pattern, [len-1] first bit received, [0] last
//   cfg_len      in   LEN_W  pattern length (0 -> 1, >PAT_W -> PAT_W)
//   cfg_overlap  in   1      1 = overlapping matches allowed
//   out          out  1      registered match pulse
//   match_count  out  CNT_W  saturating number of matches
// ---------------------------------------------------------------------------
module seq_detect_prog #(
  parameter int unsigned       PAT_W       = 4,
  parameter int unsigned       CNT_W       = 8,
  parameter logic [PAT_W-1:0]  RST_PATTERN = PAT_W'(4'b1001),
  parameter int unsigned       RST_LEN     = 4,
  parameter logic              RST_OVERLAP = 1'b1,
  localparam int unsigned      LEN_W       = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             x,
  input  logic             x_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  output logic             out,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned      FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0]  LEN_RST  = LEN_W'(RST_LEN);

  // Configuration and history state
  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              overlap_q, overlap_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              out_q, out_d;

  // Combinational helpers
  logic [LEN_W-1:0]  cfg_len_c;
  logic [PAT_W-1:0]  mask_c;
  logic [PAT_W-1:0]  cand_c;
  logic              fill_ok_c;
  logic              match_c;

  // Clamp the requested length into 1..PAT_W
  always_comb begin
    cfg_len_c = cfg_len;
    if (cfg_len == '0) begin
      cfg_len_c = LEN_W'(1);
    end else if (cfg_len > LEN_MAX) begin
      cfg_len_c = LEN_MAX;
    end
  end

  // Select the low len bits of the candidate window
  always_comb begin
    mask_c = '0;
    for (int i = 0; i < int'(PAT_W); i++) begin
      mask_c[i] = (i < int'(len_q));
    end
  end

  // Newest bit enters at [0]; the oldest relevant bit sits at [len-1]
  assign cand_c = {hist_q[PAT_W-2:0], x};

  // The history is only trusted once len-1 earlier bits have been seen
  // since the last flush; this also enforces non-overlap spacing.
  assign fill_ok_c = (int'(fill_q) >= (int'(len_q) - 1));
  assign match_c   = fill_ok_c && (((cand_c ^ pattern_q) & mask_c) == '0);

  // Next-state logic
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    out_d     = 1'b0;

    if (cfg_load) begin
      // The sample presented alongside a load is dropped
      pattern_d = cfg_pattern;
      len_d     = cfg_len_c;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (x_valid) begin
      hist_d = cand_c;
      out_d  = match_c;
      if (match_c && !overlap_q) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (clear) begin
      pattern_q <= RST_PATTERN;
      len_q     <= LEN_RST;
      overlap_q <= RST_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      out_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      out_q     <= out_d;
    end
  end

  assign out = out_q;

`ifdef MATCH_COUNT_EN
  // Saturating match counter, advances on the edge that raises out
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule
